// File: rtl/brick_move_ctrl_pkg.sv
// Shared definitions for the falling-brick movement sequencer.
// Holds board geometry, port widths, command codes, brick codes, FSM state
// encoding and the position helpers used to build move candidates.
// A position packs {row, col}; row 0 is the top of the board.
package brick_move_ctrl_pkg;

  localparam int BOARD_ROWS = 20;
  localparam int BOARD_COLS = 10;
  localparam int BOARD_SIZE = BOARD_ROWS * BOARD_COLS;  // bit index = row*BOARD_COLS + col
  localparam int BRICK_LEN  = 3;
  localparam int DIR_LEN    = 2;
  localparam int ROW_LEN    = 5;
  localparam int COL_LEN    = 4;
  localparam int POS_LEN    = ROW_LEN + COL_LEN;
  localparam int CMD_LEN    = 3;

  localparam logic [CMD_LEN-1:0] CMD_LEFT      = 3'd0;
  localparam logic [CMD_LEN-1:0] CMD_RIGHT     = 3'd1;
  localparam logic [CMD_LEN-1:0] CMD_ROT       = 3'd2;
  localparam logic [CMD_LEN-1:0] CMD_DOWN      = 3'd3;
  localparam logic [CMD_LEN-1:0] CMD_HARD_DROP = 3'd4;

  localparam logic [BRICK_LEN-1:0] BRICK_I = 3'd0;
  localparam logic [BRICK_LEN-1:0] BRICK_O = 3'd1;
  localparam logic [BRICK_LEN-1:0] BRICK_T = 3'd2;
  localparam logic [BRICK_LEN-1:0] BRICK_S = 3'd3;
  localparam logic [BRICK_LEN-1:0] BRICK_Z = 3'd4;
  localparam logic [BRICK_LEN-1:0] BRICK_J = 3'd5;
  localparam logic [BRICK_LEN-1:0] BRICK_L = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SPAWN, ST_SPAWN_CHK, ST_WAIT, ST_CHECK, ST_LOCK, ST_OVER
  } state_t;

  function automatic logic [POS_LEN-1:0] make_pos(input logic [ROW_LEN-1:0] row,
                                                  input logic [COL_LEN-1:0] col);
    return {row, col};
  endfunction

  function automatic logic [ROW_LEN-1:0] pos_row(input logic [POS_LEN-1:0] pos);
    return pos[POS_LEN-1:COL_LEN];
  endfunction

  function automatic logic [COL_LEN-1:0] pos_col(input logic [POS_LEN-1:0] pos);
    return pos[COL_LEN-1:0];
  endfunction

  // Stepping left of column 0 saturates to all-ones, which is off the board,
  // so the collision check rejects it instead of wrapping to a real column.
  function automatic logic [POS_LEN-1:0] pos_left(input logic [POS_LEN-1:0] pos);
    if (pos_col(pos) == '0) return make_pos(pos_row(pos), '1);
    return make_pos(pos_row(pos), pos_col(pos) - COL_LEN'(1));
  endfunction

  function automatic logic [POS_LEN-1:0] pos_right(input logic [POS_LEN-1:0] pos);
    if (pos_col(pos) == '1) return pos;
    return make_pos(pos_row(pos), pos_col(pos) + COL_LEN'(1));
  endfunction

  function automatic logic [POS_LEN-1:0] pos_down(input logic [POS_LEN-1:0] pos);
    if (pos_row(pos) == '1) return pos;
    return make_pos(pos_row(pos) + ROW_LEN'(1), pos_col(pos));
  endfunction

  // 4x4 occupancy mask anchored at the top-left cell; bit index = r*4 + c.
  function automatic logic [15:0] shape_mask(input logic [BRICK_LEN-1:0] brick,
                                             input logic [DIR_LEN-1:0] dir);
    logic [15:0] m;
    case (brick)
      BRICK_I: m = dir[0] ? 16'h1111 : 16'h000F;
      BRICK_S: m = dir[0] ? 16'h0231 : 16'h0036;
      BRICK_Z: m = dir[0] ? 16'h0132 : 16'h0063;
      BRICK_T: case (dir)
          2'd0: m = 16'h0027;  2'd1: m = 16'h0131;
          2'd2: m = 16'h0072;  default: m = 16'h0232;
        endcase
      BRICK_J: case (dir)
          2'd0: m = 16'h0071;  2'd1: m = 16'h0113;
          2'd2: m = 16'h0047;  default: m = 16'h0322;
        endcase
      BRICK_L: case (dir)
          2'd0: m = 16'h0074;  2'd1: m = 16'h0311;
          2'd2: m = 16'h0017;  default: m = 16'h0223;
        endcase
      default: m = 16'h0033;  // O, and the unused code behaves as O
    endcase
    return m;
  endfunction

endpackage

// File: rtl/brick_move_ctrl_collision_check.sv
// Combinational collision check for one brick placement.
// Ports:
//   board       - fill map, bit row*BOARD_COLS+col set = occupied
//   pos/dir/brick - placement to test
//   is_collided - a brick cell is off the board or on an occupied cell
module brick_move_ctrl_collision_check
  import brick_move_ctrl_pkg::*;
(
  input  logic [BOARD_SIZE-1:0] board,
  input  logic [POS_LEN-1:0]    pos,
  input  logic [DIR_LEN-1:0]    dir,
  input  logic [BRICK_LEN-1:0]  brick,
  output logic                  is_collided
);

  logic [15:0] mask;
  logic [5:0]  cell_row;
  logic [5:0]  cell_col;
  logic [7:0]  cell_idx;

  always_comb begin
    mask        = shape_mask(brick, dir);
    is_collided = 1'b0;
    cell_row    = '0;
    cell_col    = '0;
    cell_idx    = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        cell_row = {1'b0, pos_row(pos)} + 6'(r);
        cell_col = {2'b00, pos_col(pos)} + 6'(c);
        cell_idx = 8'(cell_row) * 8'(BOARD_COLS) + 8'(cell_col);
        if (mask[r*4+c]) begin
          // Bounds first: the index is meaningless for off-board cells.
          if (cell_row >= 6'(BOARD_ROWS) || cell_col >= 6'(BOARD_COLS))
            is_collided = 1'b1;
          else if (board[cell_idx])
            is_collided = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/brick_move_ctrl.sv
// Movement sequencer for the active falling brick: spawns, applies player
// commands and gravity, validates each move through one collision checker and
// raises a lock event when the brick can no longer fall.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start             - begin/restart a game (honoured in IDLE and OVER)
//   board             - current fill map
//   next_brick_type   - type used at the next spawn
//   cmd_valid/cmd/cmd_ready - command handshake (LEFT/RIGHT/ROT/DOWN/HARD_DROP)
//   cur_pos/cur_dir/cur_brick - committed brick state
//   active            - brick in play
//   lock_valid/lock_ack - lock event handshake with the board writer
//   game_over         - sticky after a spawn collision
//
// state     | meaning
// IDLE      | waiting for start
// SPAWN     | load spawn candidate
// SPAWN_CHK | check spawn candidate; commit or game over
// WAIT      | brick in play, take gravity or a command
// CHECK     | check candidate; commit, continue hard drop, lock or discard
// LOCK      | lock event pending until lock_ack
// OVER      | game over until start
module brick_move_ctrl
  import brick_move_ctrl_pkg::*;
#(
  parameter int GRAVITY_TICKS = 25000000,
  parameter int SPAWN_COL     = 4,
  parameter int SPAWN_DIR     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BOARD_SIZE-1:0] board,
  input  logic [BRICK_LEN-1:0]  next_brick_type,
  input  logic                  cmd_valid,
  input  logic [CMD_LEN-1:0]    cmd,
  output logic                  cmd_ready,
  output logic [POS_LEN-1:0]    cur_pos,
  output logic [DIR_LEN-1:0]    cur_dir,
  output logic [BRICK_LEN-1:0]  cur_brick,
  output logic                  active,
  output logic                  lock_valid,
  input  logic                  lock_ack,
  output logic                  game_over
);

  localparam int GW = $clog2(GRAVITY_TICKS + 1);
  localparam logic [POS_LEN-1:0] SPAWN_POS = make_pos('0, COL_LEN'(SPAWN_COL));
  localparam logic [DIR_LEN-1:0] SPAWN_D   = DIR_LEN'(SPAWN_DIR);

  state_t state, state_nxt;
  logic [POS_LEN-1:0]   cur_pos_nxt, cand_pos, cand_pos_nxt;
  logic [DIR_LEN-1:0]   cur_dir_nxt, cand_dir, cand_dir_nxt;
  logic [BRICK_LEN-1:0] cur_brick_nxt, cand_brick, cand_brick_nxt;
  logic cand_down, cand_down_nxt;  // candidate is a downward move: collision locks
  logic hd_flag, hd_flag_nxt;
  logic active_nxt, lock_valid_nxt, game_over_nxt;
  logic [GW-1:0] grav_cnt, grav_cnt_nxt;
  logic grav_pending, grav_pending_nxt;
  logic grav_clear;
  logic is_collided;
  logic cmd_fire;

  brick_move_ctrl_collision_check u_collision_check (
    .board       (board),
    .pos         (cand_pos),
    .dir         (cand_dir),
    .brick       (cand_brick),
    .is_collided (is_collided)
  );

  assign cmd_ready = (state == ST_WAIT) && !grav_pending && !rst;
  assign cmd_fire  = cmd_valid && cmd_ready;

  always_comb begin
    state_nxt        = state;
    cur_pos_nxt      = cur_pos;
    cur_dir_nxt      = cur_dir;
    cur_brick_nxt    = cur_brick;
    cand_pos_nxt     = cand_pos;
    cand_dir_nxt     = cand_dir;
    cand_brick_nxt   = cand_brick;
    cand_down_nxt    = cand_down;
    hd_flag_nxt      = hd_flag;
    active_nxt       = active;
    lock_valid_nxt   = lock_valid;
    game_over_nxt    = game_over;
    grav_cnt_nxt     = grav_cnt;
    grav_pending_nxt = grav_pending;
    grav_clear       = 1'b0;

    case (state)
      ST_IDLE: if (start) state_nxt = ST_SPAWN;
      ST_SPAWN: begin
        cand_pos_nxt   = SPAWN_POS;
        cand_dir_nxt   = SPAWN_D;
        cand_brick_nxt = next_brick_type;
        cand_down_nxt  = 1'b0;
        hd_flag_nxt    = 1'b0;
        state_nxt      = ST_SPAWN_CHK;
      end
      ST_SPAWN_CHK: begin
        if (is_collided) begin
          game_over_nxt = 1'b1;
          active_nxt    = 1'b0;
          state_nxt     = ST_OVER;
        end else begin
          cur_pos_nxt   = cand_pos;
          cur_dir_nxt   = cand_dir;
          cur_brick_nxt = cand_brick;
          active_nxt    = 1'b1;
          grav_clear    = 1'b1;
          state_nxt     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cand_pos_nxt   = cur_pos;
        cand_dir_nxt   = cur_dir;
        cand_brick_nxt = cur_brick;
        cand_down_nxt  = 1'b0;
        if (grav_pending) begin
          cand_pos_nxt     = pos_down(cur_pos);
          cand_down_nxt    = 1'b1;
          grav_pending_nxt = 1'b0;
          state_nxt        = ST_CHECK;
        end else if (cmd_fire) begin
          state_nxt = ST_CHECK;
          case (cmd)
            CMD_LEFT:  cand_pos_nxt = pos_left(cur_pos);
            CMD_RIGHT: cand_pos_nxt = pos_right(cur_pos);
            CMD_ROT:   cand_dir_nxt = cur_dir + DIR_LEN'(1);
            CMD_DOWN: begin
              cand_pos_nxt  = pos_down(cur_pos);
              cand_down_nxt = 1'b1;
            end
            CMD_HARD_DROP: begin
              cand_pos_nxt  = pos_down(cur_pos);
              cand_down_nxt = 1'b1;
              hd_flag_nxt   = 1'b1;
            end
            default: state_nxt = ST_WAIT;  // unknown code: consumed, no move
          endcase
        end
      end
      ST_CHECK: begin
        if (!is_collided) begin
          cur_pos_nxt   = cand_pos;
          cur_dir_nxt   = cand_dir;
          cur_brick_nxt = cand_brick;
          if (hd_flag) cand_pos_nxt = pos_down(cand_pos);
          else         state_nxt    = ST_WAIT;
        end else if (cand_down) begin
          hd_flag_nxt    = 1'b0;
          lock_valid_nxt = 1'b1;
          state_nxt      = ST_LOCK;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_LOCK: begin
        if (lock_ack) begin
          lock_valid_nxt = 1'b0;
          active_nxt     = 1'b0;
          state_nxt      = ST_SPAWN;
        end
      end
      ST_OVER: begin
        if (start) begin
          game_over_nxt = 1'b0;
          state_nxt     = ST_SPAWN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A gravity beat left over from the previous brick must not hit the new one.
    if (grav_clear) begin
      grav_cnt_nxt     = '0;
      grav_pending_nxt = 1'b0;
    end else if (active && state != ST_LOCK) begin
      if (grav_cnt == GW'(GRAVITY_TICKS - 1)) begin
        grav_cnt_nxt     = '0;
        grav_pending_nxt = 1'b1;
      end else begin
        grav_cnt_nxt = grav_cnt + GW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cur_pos      <= SPAWN_POS;
      cur_dir      <= SPAWN_D;
      cur_brick    <= '0;
      cand_pos     <= SPAWN_POS;
      cand_dir     <= SPAWN_D;
      cand_brick   <= '0;
      cand_down    <= 1'b0;
      hd_flag      <= 1'b0;
      active       <= 1'b0;
      lock_valid   <= 1'b0;
      game_over    <= 1'b0;
      grav_cnt     <= '0;
      grav_pending <= 1'b0;
    end else begin
      state        <= state_nxt;
      cur_pos      <= cur_pos_nxt;
      cur_dir      <= cur_dir_nxt;
      cur_brick    <= cur_brick_nxt;
      cand_pos     <= cand_pos_nxt;
      cand_dir     <= cand_dir_nxt;
      cand_brick   <= cand_brick_nxt;
      cand_down    <= cand_down_nxt;
      hd_flag      <= hd_flag_nxt;
      active       <= active_nxt;
      lock_valid   <= lock_valid_nxt;
      game_over    <= game_over_nxt;
      grav_cnt     <= grav_cnt_nxt;
      grav_pending <= grav_pending_nxt;
    end
  end

endmodule

// File: tb/tb_brick_move_ctrl.sv
// Directed bench for brick_move_ctrl with a short gravity period.
module tb_brick_move_ctrl;
  import brick_move_ctrl_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [BOARD_SIZE-1:0] board;
  logic [BRICK_LEN-1:0]  next_brick_type;
  logic                  cmd_valid;
  logic [CMD_LEN-1:0]    cmd;
  logic                  cmd_ready;
  logic [POS_LEN-1:0]    cur_pos;
  logic [DIR_LEN-1:0]    cur_dir;
  logic [BRICK_LEN-1:0]  cur_brick;
  logic                  active;
  logic                  lock_valid;
  logic                  lock_ack;
  logic                  game_over;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  brick_move_ctrl #(.GRAVITY_TICKS(8), .SPAWN_COL(4), .SPAWN_DIR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .board(board),
    .next_brick_type(next_brick_type), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_ready(cmd_ready), .cur_pos(cur_pos), .cur_dir(cur_dir),
    .cur_brick(cur_brick), .active(active), .lock_valid(lock_valid),
    .lock_ack(lock_ack), .game_over(game_over)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] row_now();
    return 32'(pos_row(cur_pos));
  endfunction

  function automatic logic [31:0] col_now();
    return 32'(pos_col(cur_pos));
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; cmd_valid = 1'b0; lock_ack = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  // Leaves the bench three cycles after the start pulse.
  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 40) begin
      tick(1);
      n++;
    end
    chk("cmd_ready_timeout", 32'(n < 40), 32'd1);
  endtask

  // Returns two cycles after acceptance, when the committed result is visible.
  task automatic send_cmd(input logic [2:0] c);
    wait_ready();
    cmd = c;
    cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
    tick(1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BOARD_SIZE-1:0] b;
    rst = 1'b1; start = 1'b0; cmd_valid = 1'b0; cmd = '0; lock_ack = 1'b0;
    board = '0; next_brick_type = BRICK_O;
    tick(2);
    // reset state
    chk("rst_pos", 32'(cur_pos), 32'h004);
    chk("rst_dir", 32'(cur_dir), 32'd0);
    chk("rst_brick", 32'(cur_brick), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_lock", 32'(lock_valid), 32'd0);
    chk("rst_over", 32'(game_over), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    tick(1);
    chk("idle_ready", 32'(cmd_ready), 32'd0);

    // spawn and gravity timing; start pulse at cycle N
    do_start();                                    // N+3
    chk("spawn_active", 32'(active), 32'd1);
    chk("spawn_row", row_now(), 32'd0);
    chk("spawn_col", col_now(), 32'd4);
    chk("spawn_dir", 32'(cur_dir), 32'd0);
    chk("spawn_brick", 32'(cur_brick), 32'(BRICK_O));
    chk("spawn_over", 32'(game_over), 32'd0);
    chk("spawn_ready", 32'(cmd_ready), 32'd1);
    tick(7);                                       // N+10: counter expires
    chk("grav_row_before", row_now(), 32'd0);
    tick(1);                                       // N+11: gravity pending
    chk("grav_ready_low", 32'(cmd_ready), 32'd0);
    cmd = CMD_RIGHT; cmd_valid = 1'b1;
    tick(1);                                       // N+12: CHECK
    chk("grav_check_ready", 32'(cmd_ready), 32'd0);
    tick(1);                                       // N+13
    chk("grav_row1", row_now(), 32'd1);
    chk("grav_col_held", col_now(), 32'd4);
    chk("grav_ready_back", 32'(cmd_ready), 32'd1);
    tick(1);                                       // N+14
    cmd_valid = 1'b0;
    tick(1);                                       // N+15
    chk("late_cmd_col", col_now(), 32'd5);
    tick(5);                                       // N+20
    chk("grav_row1_hold", row_now(), 32'd1);
    tick(1);                                       // N+21
    chk("grav_row2", row_now(), 32'd2);
    chk("grav_col_after", col_now(), 32'd5);

    // LEFT x5 on an open board, column 0 must not wrap
    do_reset();
    next_brick_type = BRICK_O;
    do_start();
    for (int i = 0; i < 5; i++) begin
      send_cmd(CMD_LEFT);
      chk($sformatf("left_%0d", i), col_now(), (i < 4) ? 32'(3 - i) : 32'd0);
    end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    chk("start_ignored_col", col_now(), 32'd0);
    chk("start_ignored_active", 32'(active), 32'd1);

    // occupied column 0 blocks a left move at column 1
    b = '0;
    for (int r = 0; r < BOARD_ROWS; r++) b[r*BOARD_COLS] = 1'b1;
    board = b;
    do_reset();
    do_start();
    for (int i = 0; i < 4; i++) begin
      send_cmd(CMD_LEFT);
      chk($sformatf("cell_left_%0d", i), col_now(), (i < 3) ? 32'(3 - i) : 32'd1);
    end
    board = '0;

    // hard drop: one row per cycle to row 18, then lock
    do_reset();
    next_brick_type = BRICK_O;
    do_start();
    wait_ready();
    cmd = CMD_HARD_DROP; cmd_valid = 1'b1;         // accepted at cycle N
    for (int k = 1; k <= 19; k++) begin
      tick(1);
      cmd_valid = 1'b0;
      chk($sformatf("hd_row_%0d", k), row_now(), 32'(k - 1));
      chk($sformatf("hd_ready_%0d", k), 32'(cmd_ready), 32'd0);
    end
    chk("hd_no_lock_yet", 32'(lock_valid), 32'd0);
    tick(1);                                       // N+20
    chk("hd_lock", 32'(lock_valid), 32'd1);
    chk("hd_lock_row", row_now(), 32'd18);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk($sformatf("lock_hold_%0d", k), 32'(lock_valid), 32'd1);
      chk($sformatf("lock_row_%0d", k), row_now(), 32'd18);
      chk($sformatf("lock_ready_%0d", k), 32'(cmd_ready), 32'd0);
    end
    next_brick_type = BRICK_I;
    lock_ack = 1'b1;
    tick(1);
    lock_ack = 1'b0;
    chk("ack_lock_low", 32'(lock_valid), 32'd0);
    chk("ack_inactive", 32'(active), 32'd0);
    tick(2);
    chk("respawn_active", 32'(active), 32'd1);
    chk("respawn_row", row_now(), 32'd0);
    chk("respawn_col", col_now(), 32'd4);
    chk("respawn_brick", 32'(cur_brick), 32'(BRICK_I));

    // rotation: open-space cycle, right wall, blocking cells
    do_reset();
    next_brick_type = BRICK_I;
    do_start();
    for (int i = 1; i <= 4; i++) begin
      send_cmd(CMD_ROT);
      chk($sformatf("rot_cycle_%0d", i), 32'(cur_dir), 32'(i % 4));
    end
    send_cmd(3'd6);
    chk("bad_cmd_dir", 32'(cur_dir), 32'd0);
    chk("bad_cmd_col", col_now(), 32'd4);
    send_cmd(CMD_ROT);
    chk("rot_vert", 32'(cur_dir), 32'd1);
    for (int i = 0; i < 6; i++) begin
      send_cmd(CMD_RIGHT);
      chk($sformatf("right_%0d", i), col_now(), (i < 5) ? 32'(5 + i) : 32'd9);
    end
    send_cmd(CMD_ROT);
    chk("rot_wall_dir", 32'(cur_dir), 32'd1);
    for (int i = 0; i < 3; i++) send_cmd(CMD_LEFT);
    chk("back_to_col6", col_now(), 32'd6);
    b = '0;
    for (int r = 0; r < BOARD_ROWS; r++) b[r*BOARD_COLS+8] = 1'b1;
    board = b;
    send_cmd(CMD_ROT);
    chk("rot_cell_dir", 32'(cur_dir), 32'd1);
    board = '0;
    send_cmd(CMD_ROT);
    chk("rot_open_dir", 32'(cur_dir), 32'd2);

    // spawn collision, sticky game over, restart, reset during LOCK
    b = '0;
    b[4] = 1'b1; b[5] = 1'b1; b[14] = 1'b1; b[15] = 1'b1;
    board = b;
    do_reset();
    next_brick_type = BRICK_O;
    do_start();
    chk("over_flag", 32'(game_over), 32'd1);
    chk("over_inactive", 32'(active), 32'd0);
    chk("over_ready", 32'(cmd_ready), 32'd0);
    tick(4);
    chk("over_sticky", 32'(game_over), 32'd1);
    board = '0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("restart_clear_over", 32'(game_over), 32'd0);
    tick(2);
    chk("restart_active", 32'(active), 32'd1);
    chk("restart_row", row_now(), 32'd0);
    chk("restart_col", col_now(), 32'd4);
    wait_ready();
    cmd = CMD_HARD_DROP; cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
    begin
      int n = 0;
      while (!lock_valid && n < 40) begin
        tick(1);
        n++;
      end
      chk("reach_lock", 32'(lock_valid), 32'd1);
    end
    rst = 1'b1;
    tick(1);
    chk("rst_lock_drop", 32'(lock_valid), 32'd0);
    chk("rst_lock_active", 32'(active), 32'd0);
    chk("rst_lock_pos", 32'(cur_pos), 32'h004);
    chk("rst_lock_dir", 32'(cur_dir), 32'd0);
    chk("rst_lock_brick", 32'(cur_brick), 32'd0);
    chk("rst_lock_over", 32'(game_over), 32'd0);
    chk("rst_lock_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
